// File: rtl/pico_core_q.sv
// pico_core_q: 16-bit-instruction pico core with an instruction queue,
// 8 x XLEN register file, run/step control and branch redirect.
module pico_core_q #(
    parameter int XLEN     = 8,
    parameter int IQ_DEPTH = 4,
    parameter int PC_W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        instr_valid,
    input  logic [15:0]                 instr,
    output logic                        instr_ready,
    input  logic                        run,
    input  logic                        step,
    output logic [PC_W-1:0]             pc,
    output logic                        wb_valid,
    output logic [2:0]                  wb_rd,
    output logic [XLEN-1:0]             wb_data,
    output logic                        st_valid,
    output logic [XLEN-1:0]             st_addr,
    output logic [XLEN-1:0]             st_data,
    output logic                        redirect,
    output logic [$clog2(IQ_DEPTH):0]   iq_count
);
    localparam int AW = $clog2(IQ_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(XLEN);
    localparam logic [CW-1:0]   FULL   = CW'(IQ_DEPTH);
    localparam logic [AW-1:0]   PTR1   = AW'(1);
    localparam logic [CW-1:0]   CNT1   = CW'(1);
    localparam logic [PC_W-1:0] PC1    = PC_W'(1);

    typedef enum logic [1:0] {
        OP_R  = 2'b00,
        OP_I  = 2'b01,
        OP_ST = 2'b10,
        OP_BR = 2'b11
    } op_e;

    logic [15:0]     iq_q [IQ_DEPTH];
    logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rf_q [8];
    logic [PC_W-1:0] pc_q, pc_d;
    logic            wbv_q, wbv_d, stv_q, stv_d, redir_q, redir_d;
    logic [2:0]      wbrd_q, wbrd_d;
    logic [XLEN-1:0] wbdat_q, wbdat_d, sta_q, sta_d, std_q, std_d;

    logic            push, pop, rf_we, taken, br_cond;
    logic [15:0]     head;
    op_e             op;
    logic [2:0]      rd, rs1, rs2, f3;
    logic [4:0]      imm5;
    logic [XLEN-1:0] a, b, immx, r_res, i_res;
    logic [PC_W-1:0] immb;
    logic [SW-1:0]   shamt;

    assign instr_ready = (cnt_q != FULL);
    assign push  = instr_valid && instr_ready;
    assign pop   = (cnt_q != '0) && (run || step);
    assign head  = iq_q[rptr_q];
    assign op    = op_e'(head[1:0]);
    assign rd    = head[4:2];
    assign rs1   = head[7:5];
    assign rs2   = head[10:8];
    assign imm5  = head[12:8];
    assign f3    = head[15:13];
    assign a     = (rs1 == 3'd0) ? '0 : rf_q[rs1];
    assign b     = (rs2 == 3'd0) ? '0 : rf_q[rs2];
    assign immx  = {{(XLEN-5){imm5[4]}}, imm5};
    assign immb  = {{(PC_W-5){imm5[4]}}, imm5};
    assign shamt = b[SW-1:0];

    always_comb begin
        r_res = '0;
        unique case (f3)
            3'b000: r_res = a + b;
            3'b001: r_res = a - b;
            3'b010: r_res = a & b;
            3'b011: r_res = a | b;
            3'b100: r_res = a ^ b;
            3'b101: r_res = a << shamt;
            3'b110: r_res = a >> shamt;
            3'b111: r_res = {{(XLEN-1){1'b0}}, a < b};
        endcase
    end

    always_comb begin
        i_res = immx;
        unique case (f3)
            3'b000:  i_res = a + immx;
            3'b010:  i_res = {{(XLEN-1){1'b0}}, a < immx};
            3'b011:  i_res = a & immx;
            3'b100:  i_res = a | immx;
            default: i_res = immx;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        unique case (f3[1:0])
            2'b00: br_cond = (a == b);
            2'b01: br_cond = (a != b);
            2'b10: br_cond = (a < b);
            2'b11: br_cond = (a >= b);
        endcase
    end

    always_comb begin
        pc_d    = pc_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        wbv_d   = 1'b0;
        wbrd_d  = wbrd_q;
        wbdat_d = wbdat_q;
        stv_d   = 1'b0;
        sta_d   = sta_q;
        std_d   = std_q;
        redir_d = 1'b0;
        rf_we   = 1'b0;
        taken   = 1'b0;
        if (pop) begin
            rptr_d = rptr_q + PTR1;
            pc_d   = pc_q + PC1;
            unique case (op)
                OP_R, OP_I: begin
                    if (rd != 3'd0) begin
                        rf_we   = 1'b1;
                        wbv_d   = 1'b1;
                        wbrd_d  = rd;
                        wbdat_d = (op == OP_R) ? r_res : i_res;
                    end
                end
                OP_ST: begin
                    stv_d = 1'b1;
                    sta_d = a;
                    std_d = b;
                end
                OP_BR: begin
                    if (br_cond) begin
                        taken   = 1'b1;
                        redir_d = 1'b1;
                        pc_d    = pc_q + immb;
                    end
                end
            endcase
        end
        if (push) wptr_d = wptr_q + PTR1;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT1;
            2'b01:   cnt_d = cnt_q - CNT1;
            default: cnt_d = cnt_q;
        endcase
        // A taken branch drops everything, including a same-cycle push.
        if (taken) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) iq_q[wptr_q] <= instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            pc_q    <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
            wbv_q   <= 1'b0;
            wbrd_q  <= '0;
            wbdat_q <= '0;
            stv_q   <= 1'b0;
            sta_q   <= '0;
            std_q   <= '0;
            redir_q <= 1'b0;
        end else begin
            if (rf_we) rf_q[rd] <= wbdat_d;
            pc_q    <= pc_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
            wbv_q   <= wbv_d;
            wbrd_q  <= wbrd_d;
            wbdat_q <= wbdat_d;
            stv_q   <= stv_d;
            sta_q   <= sta_d;
            std_q   <= std_d;
            redir_q <= redir_d;
        end
    end

    assign pc       = pc_q;
    assign wb_valid = wbv_q;
    assign wb_rd    = wbrd_q;
    assign wb_data  = wbdat_q;
    assign st_valid = stv_q;
    assign st_addr  = sta_q;
    assign st_data  = std_q;
    assign redirect = redir_q;
    assign iq_count = cnt_q;
endmodule

// File: tb/tb_pico_core_q.sv
// Scoreboard bench for pico_core_q: a behavioural model predicts pulses,
// a monitor compares them; plus directed scenarios and an XLEN=16 instance.
module tb_pico_core_q;
    localparam int XL = 8;
    localparam int M  = 255;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        run = 1'b1;
    logic        step = 1'b0;
    logic        instr_ready;
    logic [7:0]  pc;
    logic        wb_valid, st_valid, redirect;
    logic [2:0]  wb_rd;
    logic [7:0]  wb_data, st_addr, st_data;
    logic [2:0]  iq_count;

    logic        v16 = 1'b0;
    logic [15:0] i16 = '0;
    logic        rdy16, wbv16, stv16, red16;
    logic [7:0]  pc16;
    logic [2:0]  wbrd16;
    logic [15:0] wbd16, sta16, std16;
    logic [2:0]  cnt16;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t         expq[$];
    logic [15:0] mq[$];
    int          m_regs[8];
    int          m_pc = 0;

    pico_core_q #(.XLEN(8), .IQ_DEPTH(4), .PC_W(8)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .run(run), .step(step), .pc(pc),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .redirect(redirect), .iq_count(iq_count)
    );

    pico_core_q #(.XLEN(16), .IQ_DEPTH(4), .PC_W(8)) dut16 (
        .clk(clk), .rst(rst), .instr_valid(v16), .instr(i16),
        .instr_ready(rdy16), .run(1'b1), .step(1'b0), .pc(pc16),
        .wb_valid(wbv16), .wb_rd(wbrd16), .wb_data(wbd16),
        .st_valid(stv16), .st_addr(sta16), .st_data(std16),
        .redirect(red16), .iq_count(cnt16)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endfunction

    function automatic void exec(logic [15:0] h, output bit taken);
        int op, rd, f3, a, b, s, ix, res;
        bit c;
        op = int'(h[1:0]);
        rd = int'(h[4:2]);
        f3 = int'(h[15:13]);
        a  = m_regs[h[7:5]];
        b  = m_regs[h[10:8]];
        s  = (h[12] == 1'b1) ? int'(h[12:8]) - 32 : int'(h[12:8]);
        ix = s & M;
        taken = 1'b0;
        res = 0;
        if (op == 3) begin
            case (f3 % 4)
                0: c = (a == b);
                1: c = (a != b);
                2: c = (a < b);
                default: c = (a >= b);
            endcase
            if (c) begin
                m_pc = (m_pc + s) & 255;
                taken = 1'b1;
                expq.push_back('{4, m_pc, 0});
            end else m_pc = (m_pc + 1) & 255;
            return;
        end
        m_pc = (m_pc + 1) & 255;
        if (op == 2) begin
            expq.push_back('{2, a, b});
            return;
        end
        if (op == 0) begin
            case (f3)
                0: res = a + b;
                1: res = a - b;
                2: res = a & b;
                3: res = a | b;
                4: res = a ^ b;
                5: res = a << (b % XL);
                6: res = a >> (b % XL);
                default: res = (a < b) ? 1 : 0;
            endcase
        end else begin
            case (f3)
                0: res = a + ix;
                2: res = (a < ix) ? 1 : 0;
                3: res = a & ix;
                4: res = a | ix;
                default: res = ix;
            endcase
        end
        if (rd != 0) begin
            m_regs[rd] = res & M;
            expq.push_back('{1, rd, res & M});
        end
    endfunction

    function automatic void model_edge(bit r, bit v, logic [15:0] ins,
                                       bit ru, bit st);
        bit rdy, psh, pp, tk;
        logic [15:0] h;
        if (r) begin
            mq.delete();
            m_pc = 0;
            foreach (m_regs[i]) m_regs[i] = 0;
            return;
        end
        rdy = mq.size() < DEPTH;
        psh = v && rdy;
        pp  = (mq.size() > 0) && (ru || st);
        tk  = 1'b0;
        if (pp) begin
            h = mq.pop_front();
            exec(h, tk);
        end
        if (tk) mq.delete();
        else if (psh) mq.push_back(ins);
    endfunction

    task automatic cyc(bit r, bit v, logic [15:0] ins, bit ru, bit st);
        @(negedge clk);
        rst = r;
        instr_valid = v;
        instr = ins;
        run = ru;
        step = st;
        model_edge(r, v, ins, ru, st);
    endtask

    task automatic after();
        @(posedge clk);
        #2;
    endtask

    task automatic t16(logic [15:0] ins, int rd, int exp, string nm);
        @(negedge clk);
        v16 = 1'b1;
        i16 = ins;
        @(negedge clk);
        v16 = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_wbv"}, wbv16, 1);
        chk({nm, "_rd"}, wbrd16, rd);
        chk({nm, "_data"}, wbd16, exp);
    endtask

    initial begin
        ev_t e;
        int  k;
        forever begin
            @(posedge clk);
            #1;
            chk("pc", pc, m_pc);
            chk("iq_count", iq_count, mq.size());
            chk("instr_ready", instr_ready, (mq.size() < DEPTH) ? 1 : 0);
            k = int'({redirect, st_valid, wb_valid});
            if (k != 0) begin
                if (expq.size() == 0) chk("unexpected_pulse", k, 0);
                else begin
                    e = expq.pop_front();
                    chk("pulse_kind", k, e.kind);
                    if (e.kind == 1) begin
                        chk("wb_rd", wb_rd, e.a);
                        chk("wb_data", wb_data, e.b);
                    end else if (e.kind == 2) begin
                        chk("st_addr", st_addr, e.a);
                        chk("st_data", st_data, e.b);
                    end
                end
            end
        end
    end

    initial begin
        foreach (m_regs[i]) m_regs[i] = 0;
        cyc(1, 0, 16'h0, 1, 0);
        after();
        chk("rst_wbv", wb_valid, 0);
        chk("rst_wbdata", wb_data, 0);
        chk("rst_stv", st_valid, 0);
        chk("rst_ready", instr_ready, 1);
        cyc(0, 0, 16'h0, 1, 0);

        t16(16'h0F09, 2, 16'h000F, "x16_addi15");
        t16(16'h0449, 2, 16'h0013, "x16_addi4");
        t16(16'h0105, 1, 16'h0001, "x16_addi1");
        t16(16'hA22C, 3, 16'h0008, "x16_sll");
        t16(16'h1F11, 4, 16'hFFFF, "x16_addim1");

        cyc(0, 1, 16'h0505, 1, 0);
        cyc(0, 1, 16'h1D09, 1, 0);
        cyc(0, 1, 16'h022C, 1, 0);
        cyc(0, 0, 16'h0, 1, 0);
        after();
        chk("seq_pc", pc, 3);
        chk("seq_rd", wb_rd, 3);
        chk("seq_data", wb_data, 2);

        cyc(0, 1, 16'h2323, 1, 0);
        cyc(0, 1, 16'h0505, 1, 0);
        after();
        chk("br_redirect", redirect, 1);
        chk("br_pc", pc, 6);
        chk("br_iq", iq_count, 0);
        cyc(0, 0, 16'h0, 1, 0);
        after();
        chk("br_pulse_end", redirect, 0);
        chk("br_no_wb", wb_valid, 0);

        cyc(0, 1, 16'h0222, 1, 0);
        cyc(0, 1, 16'h0701, 1, 0);
        after();
        chk("st_valid", st_valid, 1);
        chk("st_addr_d", st_addr, 8'h05);
        chk("st_data_d", st_data, 8'hFD);
        cyc(0, 1, 16'h0114, 1, 0);
        after();
        chk("r0_no_wb", wb_valid, 0);
        cyc(0, 0, 16'h0, 1, 0);
        after();
        chk("r0_reads0", wb_data, 5);

        cyc(0, 1, 16'h0105, 0, 0);
        cyc(0, 1, 16'h0209, 0, 0);
        cyc(0, 1, 16'h022C, 0, 0);
        cyc(0, 1, 16'h0222, 0, 0);
        cyc(0, 1, 16'h0530, 0, 0);
        after();
        chk("step_full", iq_count, 4);
        chk("step_ready", instr_ready, 0);
        cyc(0, 0, 16'h0, 0, 1);
        after();
        chk("step_one", iq_count, 3);
        cyc(0, 0, 16'h0, 0, 0);
        cyc(1, 0, 16'h0, 1, 0);
        after();
        chk("mrst_iq", iq_count, 0);
        chk("mrst_pc", pc, 0);
        chk("mrst_pulse", int'({redirect, st_valid, wb_valid}), 0);
        cyc(0, 1, 16'h0224, 1, 0);
        cyc(0, 0, 16'h0, 1, 0);
        after();
        chk("mrst_regs", wb_data, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 300) == 0, ($urandom % 4) != 0,
                16'($urandom), ($urandom % 4) != 0, $urandom % 2);
        end
        repeat (8) cyc(0, 0, 16'h0, 1, 0);
        after();
        chk("leftover_events", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
